// File: rtl/rom_loader_if.sv
// Byte-stream and memory-write bundle of the ROM loader.
// slave  : the loader (consumes bytes, drives the byte write port).
// master : the surroundings (byte source plus the instruction memory).
interface rom_loader_if #(
  parameter int ADDR_W = 32
) ();
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [7:0]        wdata_o;

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/rom_loader.sv
// Instruction ROM loader: parses a framed byte stream (sync, 32-bit length,
// payload, 8-bit additive checksum), writes the payload byte by byte into the
// instruction memory and keeps the core in reset until a verified image is in.
module rom_loader #(
  parameter int ROM_SIZE = 4096,
  parameter int ADDR_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  rom_loader_if.slave  bus,
  output logic         cpu_hold_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN, DATA, CSUM, DONE, ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       len_reg, len_next;
  logic [1:0]        len_cnt_reg, len_cnt_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [7:0]        sum_reg, sum_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [7:0]        wdata_reg, wdata_next;

  logic              byte_ready;
  logic              accept;
  logic [31:0]       len_shift;

  // Ready and status flags depend on the state only.
  assign byte_ready = (state_reg == SYNC) || (state_reg == LEN) ||
                      (state_reg == DATA) || (state_reg == CSUM);
  assign busy_o     = byte_ready;
  assign done_o     = (state_reg == DONE);
  assign err_o      = (state_reg == ERR);
  // The core only runs when idle after reset or after a good image.
  assign cpu_hold_o = (state_reg != IDLE) && (state_reg != DONE);

  assign bus.byte_ready_o = byte_ready;
  assign bus.we_o         = we_reg;
  assign bus.waddr_o      = waddr_reg;
  assign bus.wdata_o      = wdata_reg;

  // State and datapath registers; reset returns every output to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      len_cnt_reg <= '0;
      idx_reg     <= '0;
      sum_reg     <= '0;
      we_reg      <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      len_cnt_reg <= len_cnt_next;
      idx_reg     <= idx_next;
      sum_reg     <= sum_next;
      we_reg      <= we_next;
      waddr_reg   <= waddr_next;
      wdata_reg   <= wdata_next;
    end
  end

  // Frame parser: next state, length/index/sum updates and the write request.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    len_cnt_next = len_cnt_reg;
    idx_next     = idx_reg;
    sum_next     = sum_reg;
    we_next      = 1'b0;
    waddr_next   = waddr_reg;
    wdata_next   = wdata_reg;
    accept       = byte_ready && bus.byte_valid_i;
    len_shift    = {len_reg[23:0], bus.byte_data_i};

    case (state_reg)
      IDLE: begin
        if (start_i) state_next = SYNC;
      end
      SYNC: begin
        if (accept && (bus.byte_data_i == 8'hA5)) begin
          state_next   = LEN;
          len_next     = '0;
          len_cnt_next = '0;
          idx_next     = '0;
          sum_next     = '0;
        end
      end
      LEN: begin
        if (accept) begin
          len_next     = len_shift;
          len_cnt_next = len_cnt_reg + 2'd1;
          if (len_cnt_reg == 2'd3) begin
            if (len_shift > 32'(ROM_SIZE))  state_next = ERR;
            else if (len_shift == 32'd0)    state_next = CSUM;
            else                            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_next    = 1'b1;
          waddr_next = idx_reg;
          wdata_next = bus.byte_data_i;
          sum_next   = sum_reg + bus.byte_data_i;
          // Index is held on the last byte so it never reaches ROM_SIZE.
          if (32'(idx_reg) == (len_reg - 32'd1)) state_next = CSUM;
          else                                   idx_next   = idx_reg + ADDR_W'(1);
        end
      end
      CSUM: begin
        if (accept) state_next = (bus.byte_data_i == sum_reg) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (start_i) state_next = SYNC;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: frames are built by the bench, which tags each
// payload byte with its address; a compare process checks the write port every
// cycle against the write each accepted payload byte must produce.
module tb_rom_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, busy, done, err;

  rom_loader_if #(.ADDR_W(32)) bus ();

  rom_loader #(.ROM_SIZE(4096), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .bus        (bus),
    .cpu_hold_o (cpu_hold),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  // Tag of the byte currently offered: payload flag and its byte address.
  bit          cur_pl = 1'b0;
  int          cur_idx = 0;

  // Expected write port, one cycle behind each accepted payload byte.
  logic        pend_we = 1'b0;
  logic [31:0] keep_addr = '0;
  logic [7:0]  keep_data = '0;

  int          wr_cnt = 0;
  logic [7:0]  mem [0:4095];
  logic [7:0]  payload [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted payload byte k must appear as write(k, byte) next cycle.
  always @(posedge clk) begin
    if (rst) begin
      pend_we   <= 1'b0;
      keep_addr <= '0;
      keep_data <= '0;
    end else if (bus.byte_valid_i && bus.byte_ready_o && cur_pl) begin
      pend_we   <= 1'b1;
      keep_addr <= 32'(cur_idx);
      keep_data <= bus.byte_data_i;
    end else begin
      pend_we   <= 1'b0;
    end
  end

  // Cycle-by-cycle check of the write port; also mirrors writes into memory.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we_o", 32'(bus.we_o), 32'(pend_we));
      chk("waddr_o", bus.waddr_o, keep_addr);
      chk("wdata_o", 32'(bus.wdata_o), 32'(keep_data));
      if (bus.we_o) begin
        mem[bus.waddr_o[11:0]] = bus.wdata_o;
        wr_cnt++;
      end
    end
  end

  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + payload[i];
    return s;
  endfunction

  // Offer one byte until accepted (bounded); returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit pl, input int idx, input int gap);
    bit got = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    cur_pl  = pl;
    cur_idx = idx;
    for (int t = 0; t < 40 && !got; t++) begin
      got = bus.byte_ready_o;
      @(negedge clk);
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: byte 0x%0h not accepted within 40 cycles", b);
    end
    bus.byte_valid_i = 1'b0;
    cur_pl = 1'b0;
  endtask

  function automatic int gap_of(input bit gaps);
    return gaps ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Sync, big-endian length, first n payload bytes (abort after 'stop' if >0), checksum.
  task automatic send_frame(input logic [31:0] len, input int n, input logic [7:0] csum,
                            input bit with_csum, input bit gaps, input int stop);
    send_byte(8'hA5, 1'b0, 0, gap_of(gaps));
    for (int i = 0; i < 4; i++) send_byte(len[31-8*i -: 8], 1'b0, 0, gap_of(gaps));
    for (int i = 0; i < n; i++) begin
      send_byte(payload[i], 1'b1, i, gap_of(gaps));
      if (stop == i + 1) return;
    end
    if (with_csum) send_byte(csum, 1'b0, 0, gap_of(gaps));
  endtask

  task automatic pulse_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_hold"},  32'(cpu_hold), 32'd1);
    chk({name, "_busy"},  32'(busy), 32'd1);
    chk({name, "_done"},  32'(done), 32'd0);
    chk({name, "_err"},   32'(err), 32'd0);
  endtask

  task automatic check_status(input string name, input bit e_done, input bit e_err,
                              input bit e_hold, input int e_writes, input int base);
    chk({name, "_done"},   32'(done), 32'(e_done));
    chk({name, "_err"},    32'(err), 32'(e_err));
    chk({name, "_hold"},   32'(cpu_hold), 32'(e_hold));
    chk({name, "_busy"},   32'(busy), 32'd0);
    chk({name, "_ready"},  32'(bus.byte_ready_o), 32'd0);
    chk({name, "_writes"}, 32'(wr_cnt - base), 32'(e_writes));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_we"},    32'(bus.we_o), 32'd0);
    chk({name, "_waddr"}, bus.waddr_o, 32'd0);
    chk({name, "_wdata"}, 32'(bus.wdata_o), 32'd0);
    chk({name, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    chk({name, "_hold"},  32'(cpu_hold), 32'd0);
    chk({name, "_busy"},  32'(busy), 32'd0);
    chk({name, "_done"},  32'(done), 32'd0);
    chk({name, "_err"},   32'(err), 32'd0);
  endtask

  int base;

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    payload[0] = 8'h00; payload[1] = 8'h00; payload[2] = 8'h00; payload[3] = 8'h13;
    payload[4] = 8'h12; payload[5] = 8'h34; payload[6] = 8'h56; payload[7] = 8'h78;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("model_csum", 32'(model_csum(8)), 32'h27);

    // Good load
    pulse_start("good_start");
    base = wr_cnt;
    send_frame(32'd8, 8, 8'h27, 1'b1, 1'b0, 0);
    check_status("good", 1'b1, 1'b0, 1'b0, 8, base);
    chk("good_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h00000013);
    chk("good_word1", {mem[4], mem[5], mem[6], mem[7]}, 32'h12345678);
    $display("good load: writes=%0d done=%0b", wr_cnt - base, done);

    // Sync hunt: junk before the sync byte must not write
    pulse_start("hunt_start");
    base = wr_cnt;
    send_byte(8'h00, 1'b0, 0, 0);
    send_byte(8'hFF, 1'b0, 0, 0);
    send_byte(8'h5A, 1'b0, 0, 0);
    send_frame(32'd8, 8, model_csum(8), 1'b1, 1'b0, 0);
    check_status("hunt", 1'b1, 1'b0, 1'b0, 8, base);
    $display("sync hunt: writes=%0d done=%0b", wr_cnt - base, done);

    // Oversize length 4097: error right after the 4th length byte
    pulse_start("over_start");
    base = wr_cnt;
    send_frame(32'd4097, 0, 8'h00, 1'b0, 1'b0, 0);
    check_status("over", 1'b0, 1'b1, 1'b1, 0, base);
    repeat (3) @(negedge clk);
    check_status("over_later", 1'b0, 1'b1, 1'b1, 0, base);
    $display("oversize: err=%0b hold=%0b", err, cpu_hold);

    // Bad checksum, then a correct reload
    pulse_start("bad_start");
    base = wr_cnt;
    send_frame(32'd8, 8, 8'h28, 1'b1, 1'b0, 0);
    check_status("bad", 1'b0, 1'b1, 1'b1, 8, base);
    $display("bad checksum: writes=%0d err=%0b", wr_cnt - base, err);
    pulse_start("reload_start");
    base = wr_cnt;
    send_frame(32'd8, 8, 8'h27, 1'b1, 1'b0, 0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 8, base);
    $display("reload: writes=%0d done=%0b", wr_cnt - base, done);

    // Random valid gaps
    for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
    pulse_start("gap_start");
    base = wr_cnt;
    send_frame(32'd8, 8, 8'h27, 1'b1, 1'b1, 0);
    check_status("gap", 1'b1, 1'b0, 1'b0, 8, base);
    chk("gap_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h00000013);
    chk("gap_word1", {mem[4], mem[5], mem[6], mem[7]}, 32'h12345678);
    $display("gapped load: writes=%0d done=%0b", wr_cnt - base, done);

    // Empty image
    pulse_start("empty_start");
    base = wr_cnt;
    send_frame(32'd0, 0, 8'h00, 1'b1, 1'b0, 0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 0, base);
    $display("empty image: writes=%0d done=%0b", wr_cnt - base, done);

    // Reset after the 3rd payload byte is accepted
    pulse_start("abort_start");
    base = wr_cnt;
    send_frame(32'd8, 8, 8'h27, 1'b1, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort_rst");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort_idle");
    chk("abort_writes", 32'(wr_cnt - base), 32'd3);
    $display("reset mid-load: writes=%0d hold=%0b", wr_cnt - base, cpu_hold);
    pulse_start("fresh_start");
    base = wr_cnt;
    send_frame(32'd8, 8, 8'h27, 1'b1, 1'b0, 0);
    check_status("fresh", 1'b1, 1'b0, 1'b0, 8, base);
    $display("fresh load: writes=%0d done=%0b", wr_cnt - base, done);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the instruction ROM. Receives a framed byte stream over a valid/ready byte interface (e.g. from a UART receiver) and writes the payload into the byte-organised instruction memory, one byte per write.
- Holds the core in reset while loading and releases it on a verified image.
- Byte k of the payload goes to byte address k, so the instruction at word address A is sent MSB first: byte A+0 (instruction bits 31:24) through byte A+3 (bits 7:0).

Parameters:
- ROM_SIZE, 4096, instruction memory size in bytes; the largest accepted payload length.
- ADDR_W, 32, width of the write address, matching the memory address bus.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  single-cycle request to begin a load
- byte_valid_i  in  1  input byte is valid
- byte_data_i  in  8  input byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- we_o  out  1  byte write enable to instruction memory
- waddr_o  out  ADDR_W  byte write address
- wdata_o  out  8  byte write data
- cpu_hold_o  out  1  holds the core in reset
- busy_o  out  1  load in progress (states SYNC, LEN, DATA, CSUM)
- done_o  out  1  last load completed with a good checksum
- err_o  out  1  last load failed

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset is registered on clk; rst wins over every other input.
- A byte is accepted when byte_valid_i and byte_ready_o are both 1 in the same cycle. byte_ready_o is a pure function of the state: 1 in SYNC, LEN, DATA and CSUM, 0 otherwise.
- Frame format: sync byte 0xA5, then a 4-byte length (big-endian, MSB first), then length payload bytes, then one checksum byte. The checksum is the 8-bit sum of the payload, modulo 256.
- State IDLE:
  - cpu_hold_o = 0.
  - start_i moves to SYNC; cpu_hold_o goes to 1 from the next cycle.
- State SYNC:
  - Accepted bytes other than 0xA5 are discarded.
  - 0xA5 moves to LEN and clears the byte counter, the index and the sum.
- State LEN:
  - Accepts 4 bytes, shifting them into a 32-bit length register.
  - After the 4th byte: length > ROM_SIZE goes to ERR; length == 0 goes to CSUM; otherwise goes to DATA.
- State DATA:
  - Each accepted byte produces a registered write: in the cycle after acceptance, we_o = 1, waddr_o = index, wdata_o = byte. Index and sum update on acceptance.
  - we_o is a one-cycle pulse per byte.
  - Back-to-back valid bytes give one write per cycle; there is no backpressure in DATA.
  - Acceptance of byte index length-1 moves to CSUM.
  - Index width is ADDR_W; the index never exceeds ROM_SIZE-1.
- State CSUM:
  - Accepts one byte. Byte equal to the sum goes to DONE; any other value goes to ERR.
  - The final DATA write (registered) still occurs in the first CSUM cycle.
- State DONE: done_o = 1, cpu_hold_o = 0, busy_o = 0.
- State ERR: err_o = 1, cpu_hold_o stays 1 (the core never runs a partial image), busy_o = 0.
- From DONE or ERR, start_i moves to SYNC, clears done_o/err_o and sets cpu_hold_o.
- start_i while busy is ignored.
- Reset mid-load:
  - Aborts the load; no further writes are issued.
  - Memory contents are undefined (possibly partial).
  - Outputs return to their reset values, so cpu_hold_o = 0. The system must reissue start_i before letting the core run.
- The accept-to-write latency is exactly 1 cycle. waddr_o and wdata_o hold their last values when we_o = 0.

Test Plan:
- Good load: start_i; send A5 00 00 00 08 00 00 00 13 12 34 56 78 27 -> 8 writes to addresses 0..7 with data 00,00,00,13,12,34,56,78. Then done_o = 1, err_o = 0, cpu_hold_o = 0. The memory word at address 0 reads 0x00000013.
- Sync hunt: send 00 FF 5A, then the good frame -> no write before the 0xA5 is accepted, identical result to the good load.
- Oversize: length bytes 00 00 10 01 (4097) -> ERR immediately after the 4th length byte. Zero writes, err_o = 1, cpu_hold_o = 1, byte_ready_o = 0.
- Bad checksum: good frame with checksum 0x28 -> all 8 writes occur, then err_o = 1, done_o = 0, cpu_hold_o = 1. A new start_i with the correct frame then gives done_o = 1.
- Flow control and empty image:
  - Random byte_valid_i gaps -> writes are identical to the good load, one cycle after each acceptance.
  - Frame A5 00 00 00 00 00 -> done_o = 1 with zero writes.
- Reset mid-load: assert rst after the 3rd payload byte is accepted -> from the next cycle we_o = 0, all outputs 0, state IDLE. A fresh start_i and full frame then complete with done_o = 1.
